// File: rtl/fft_avalon_master_slave.sv
// fft_avalon_master_slave: Avalon-MM slave fills a sample SRAM; a write master streams it to memory on start
module fft_avalon_master_slave #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH = 9,
  parameter int DATAWIDTH = 32,
  parameter int SRAM_DATAWIDTH = 16,
  parameter int SRAM_WORDS = 512,
  parameter logic [SLAVE_ADDRESSWIDTH-1:0] START_ADDR = 9'h1FF,
  parameter logic [SLAVE_ADDRESSWIDTH-1:0] DEST_ADDR = 9'h1FE
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           slave_chipselect,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           f_wren,
  output logic                           f_rden,
  output logic [SRAM_DATAWIDTH-1:0]      f_data,
  output logic [SLAVE_ADDRESSWIDTH-1:0]  f_address,
  input  logic [SRAM_DATAWIDTH-1:0]      f_q
);
  localparam int IW = $clog2(SRAM_WORDS);
  typedef enum logic [2:0] {IDLE, RD, WQ, WR, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [SRAM_DATAWIDTH-1:0] data_q;
  logic [MASTER_ADDRESSWIDTH-1:0] dest_base;
  logic done, busy, is_sram, s_wr, s_rd, sram_wr, sram_rd, start, xfer, last;
  logic rd_sram_q;
  logic [DATAWIDTH-1:0] rd_reg_q;
  logic unused_ok;
  assign unused_ok = ^{master_readdata, master_readdatavalid};
  assign busy = (state == RD) | (state == WQ) | (state == WR);
  assign is_sram = slave_address < DEST_ADDR;
  assign s_wr = slave_chipselect & slave_write;
  assign s_rd = slave_chipselect & slave_read;
  assign sram_wr = s_wr & is_sram & ~busy;
  assign sram_rd = s_rd & is_sram & ~busy & ~s_wr;
  assign start = s_wr & (slave_address == START_ADDR) & (state == IDLE);
  assign xfer = (state == WR) & ~master_waitrequest;
  assign last = idx == IW'(SRAM_WORDS - 1);
  assign master_read = 1'b0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RD : IDLE;
      RD:   state_nx = WQ;
      WQ:   state_nx = WR;
      WR:   state_nx = xfer ? (last ? DONE : RD) : WR;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    f_wren = sram_wr;
    f_rden = (state == RD) | sram_rd;
    f_address = (state == RD) ? SLAVE_ADDRESSWIDTH'(idx) : (sram_wr | sram_rd) ? slave_address : '0;
    f_data = sram_wr ? slave_writedata[SRAM_DATAWIDTH-1:0] : '0;
    master_write = state == WR;
    master_address = (state == WR) ? dest_base + (MASTER_ADDRESSWIDTH'(idx) << 2) : '0;
    master_writedata = (state == WR) ? DATAWIDTH'(data_q) : '0;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      idx <= '0;
      data_q <= '0;
      dest_base <= '0;
      done <= 1'b0;
      rd_sram_q <= 1'b0;
      rd_reg_q <= '0;
    end else begin
      idx <= start ? '0 : (xfer & ~last) ? idx + 1'b1 : idx;
      data_q <= (state == WQ) ? f_q : data_q;
      dest_base <= (s_wr & (slave_address == DEST_ADDR) & ~busy) ? slave_writedata[MASTER_ADDRESSWIDTH-1:0] : dest_base;
      done <= start ? 1'b0 : (xfer & last) ? 1'b1 : done;
      rd_sram_q <= sram_rd;
      rd_reg_q <= ~s_rd ? '0 :
                  (slave_address == START_ADDR) ? DATAWIDTH'({done, busy}) :
                  (slave_address == DEST_ADDR) ? DATAWIDTH'(dest_base) : '0;
    end
  // SRAM data arrives the cycle after f_rden, so it is muxed in behind the registered select
  assign slave_readdata = rd_sram_q ? DATAWIDTH'(f_q) : rd_reg_q;
endmodule

// File: tb/tb_fft_avalon_master_slave.sv
// tb_fft_avalon_master_slave: directed bench with SRAM model, write-master monitor and stall responder
module tb_fft_avalon_master_slave;
  logic clk = 0, n_rst = 0;
  logic cs = 0, rd = 0, wr = 0;
  logic [8:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] slave_readdata, master_address, master_writedata;
  logic master_write, master_read, master_waitrequest = 0;
  logic f_wren, f_rden;
  logic [15:0] f_data, f_q = 0;
  logic [8:0] f_address;
  logic [15:0] mem [512];
  int vec = 0, errs = 0;
  int wr_cnt = 0, stall_cyc = 0, stab_err = 0, gap_err = 0, ovl_err = 0;
  logic [31:0] addr_log [4096];
  logic [31:0] data_log [4096];
  logic prev_stall = 0, prev_w = 0;
  logic [31:0] prev_addr = 0, prev_data = 0;
  int low_run = 100;
  bit stall_mode = 0;
  int wcnt = 0;

  fft_avalon_master_slave dut (
    .clk(clk), .n_rst(n_rst),
    .slave_chipselect(cs), .slave_read(rd), .slave_write(wr),
    .slave_address(addr), .slave_writedata(wdata), .slave_readdata(slave_readdata),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_read(master_read),
    .master_readdata(32'h0), .master_readdatavalid(1'b0),
    .master_waitrequest(master_waitrequest),
    .f_wren(f_wren), .f_rden(f_rden), .f_data(f_data), .f_address(f_address), .f_q(f_q)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 512; i++) mem[i] = 16'hBEEF;

  always @(posedge clk) begin
    if (f_wren) mem[f_address] <= f_data;
    if (f_rden) f_q <= mem[f_address];
  end

  always @(posedge clk) begin
    if (f_wren && f_rden) ovl_err++;
    if (master_write) begin
      if (!prev_w && low_run < 2) gap_err++;
      if (prev_stall && (master_address !== prev_addr || master_writedata !== prev_data)) stab_err++;
      if (master_waitrequest) stall_cyc++;
      else begin
        addr_log[wr_cnt % 4096] = master_address;
        data_log[wr_cnt % 4096] = master_writedata;
        wr_cnt++;
      end
      prev_stall = master_waitrequest;
      prev_addr = master_address;
      prev_data = master_writedata;
      low_run = 0;
    end else begin
      prev_stall = 0;
      low_run++;
    end
    prev_w = master_write;
  end

  always @(negedge clk)
    if (master_write) begin
      master_waitrequest = stall_mode && wcnt < 3;
      wcnt++;
    end else begin
      wcnt = 0;
      master_waitrequest = 0;
    end

  function automatic logic [31:0] exp_data(input int k);
    return k < 256 ? 32'h100 : k < 510 ? 32'h0 : 32'hBEEF;
  endfunction

  function automatic int log_errs(input int base, input logic [31:0] dest);
    int n = 0;
    for (int k = 0; k < 512; k++)
      if (addr_log[(base + k) % 4096] !== dest + 32'(4 * k) || data_log[(base + k) % 4096] !== exp_data(k)) n++;
    return n;
  endfunction

  task automatic sw(input logic [8:0] a, input logic [31:0] d, input int n);
    @(negedge clk); cs = 1; wr = 1; addr = a; wdata = d;
    repeat (n) @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic sr(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1; rd = 1; addr = a;
    @(negedge clk); d = slave_readdata; cs = 0; rd = 0;
  endtask

  task automatic wait_words(input int target, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (wr_cnt >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #1;
    vec++;
    if ({slave_readdata, master_address, master_writedata, master_write, master_read, f_wren, f_rden, f_data, f_address} !== '0) begin
      errs++; $display("FAIL reset_outputs: got ra=%h ma=%h md=%h mw=%b fw=%b fr=%b fa=%h, want all 0",
        slave_readdata, master_address, master_writedata, master_write, f_wren, f_rden, f_address);
    end
    repeat (2) @(negedge clk);
    n_rst = 1;
    sr(9'h1FF, d);
    vec++;
    if (d !== 32'h0) begin errs++; $display("FAIL reset_ctrl: got %h want 00000000", d); end
  endtask

  task automatic test_sram_load;
    logic [31:0] d;
    int bad = 0;
    @(negedge clk); cs = 1; wr = 1; addr = 9'd7; wdata = 32'hABCD0100;
    #1;
    vec++;
    if ({f_wren, f_rden, f_address, f_data} !== {1'b1, 1'b0, 9'd7, 16'h0100}) begin
      errs++; $display("FAIL sram_write_strobe: got wren=%b rden=%b addr=%h data=%h want 1 0 007 0100", f_wren, f_rden, f_address, f_data);
    end
    @(negedge clk); cs = 0; wr = 0;
    for (int i = 0; i < 510; i++) sw(9'(i), i < 256 ? 32'h100 : 32'h0, 3);
    for (int i = 0; i < 510; i++) if (mem[i] !== exp_data(i)) bad++;
    vec++;
    if (bad != 0) begin errs++; $display("FAIL sram_contents: %0d bad words, want 0", bad); end
    @(negedge clk); cs = 1; rd = 1; addr = 9'd3;
    #1;
    vec++;
    if ({f_rden, f_wren, f_address} !== {1'b1, 1'b0, 9'd3}) begin
      errs++; $display("FAIL sram_read_strobe: got rden=%b wren=%b addr=%h want 1 0 003", f_rden, f_wren, f_address);
    end
    @(negedge clk); cs = 0; rd = 0;
    sr(9'd0, d);
    vec++; if (d !== 32'h100) begin errs++; $display("FAIL read_w0: got %h want 00000100", d); end
    sr(9'd255, d);
    vec++; if (d !== 32'h100) begin errs++; $display("FAIL read_w255: got %h want 00000100", d); end
    sr(9'd256, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL read_w256: got %h want 00000000", d); end
    sr(9'd509, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL read_w509: got %h want 00000000", d); end
    @(negedge clk); rd = 1; addr = 9'd1;
    #1;
    vec++;
    if (f_rden !== 1'b0) begin errs++; $display("FAIL read_no_cs: got rden=%b want 0", f_rden); end
    @(negedge clk); rd = 0;
  endtask

  task automatic test_run_basic;
    logic [31:0] d;
    bit ok;
    int base, gap0;
    sw(9'h1FE, 32'h1000, 1);
    sr(9'h1FE, d);
    vec++; if (d !== 32'h1000) begin errs++; $display("FAIL dest_readback: got %h want 00001000", d); end
    base = wr_cnt; gap0 = gap_err;
    sw(9'h1FF, 32'h0, 1);
    sr(9'h1FF, d);
    vec++; if (d !== 32'h1) begin errs++; $display("FAIL busy_after_start: got %h want 00000001", d); end
    wait_words(base + 512, 3000, ok);
    vec++; if (!ok) begin errs++; $display("FAIL run_timeout: got %0d writes want 512", wr_cnt - base); end
    vec++;
    if (addr_log[base % 4096] !== 32'h1000 || data_log[base % 4096] !== 32'h100) begin
      errs++; $display("FAIL first_write: got %h/%h want 00001000/00000100", addr_log[base % 4096], data_log[base % 4096]);
    end
    vec++;
    if (addr_log[(base + 511) % 4096] !== 32'h17FC) begin
      errs++; $display("FAIL last_write: got %h want 000017fc", addr_log[(base + 511) % 4096]);
    end
    vec++; if (log_errs(base, 32'h1000) != 0) begin errs++; $display("FAIL run_sequence: got %0d bad writes want 0", log_errs(base, 32'h1000)); end
    vec++; if (gap_err != gap0) begin errs++; $display("FAIL write_gap: got %0d short gaps want 0", gap_err - gap0); end
    sr(9'h1FF, d);
    vec++; if (d !== 32'h2) begin errs++; $display("FAIL done_status: got %h want 00000002", d); end
    vec++; if (wr_cnt != base + 512) begin errs++; $display("FAIL run_count: got %0d want 512", wr_cnt - base); end
  endtask

  task automatic test_waitrequest;
    logic [31:0] d;
    bit ok;
    int base, st0, sc0;
    stall_mode = 1;
    base = wr_cnt; st0 = stab_err; sc0 = stall_cyc;
    sw(9'h1FF, 32'h0, 1);
    wait_words(base + 512, 6000, ok);
    vec++; if (!ok) begin errs++; $display("FAIL stall_timeout: got %0d writes want 512", wr_cnt - base); end
    repeat (5) @(negedge clk);
    vec++; if (wr_cnt != base + 512) begin errs++; $display("FAIL stall_count: got %0d want 512", wr_cnt - base); end
    vec++; if (stab_err != st0) begin errs++; $display("FAIL stall_stable: got %0d changes want 0", stab_err - st0); end
    vec++; if (stall_cyc - sc0 != 1536) begin errs++; $display("FAIL stall_cycles: got %0d want 1536", stall_cyc - sc0); end
    vec++; if (log_errs(base, 32'h1000) != 0) begin errs++; $display("FAIL stall_sequence: got %0d bad want 0", log_errs(base, 32'h1000)); end
    sr(9'h1FF, d);
    vec++; if (d !== 32'h2) begin errs++; $display("FAIL stall_done: got %h want 00000002", d); end
    stall_mode = 0;
  endtask

  task automatic test_midrun_pokes;
    logic [31:0] d;
    bit ok;
    int base;
    sw(9'h1FE, 32'h2000, 1);
    base = wr_cnt;
    sw(9'h1FF, 32'h0, 1);
    repeat (20) @(negedge clk);
    sw(9'h1FF, 32'h0, 3);
    sw(9'd5, 32'h7777, 3);
    sw(9'h1FE, 32'h9999, 2);
    sr(9'd5, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL busy_sram_read: got %h want 00000000", d); end
    sr(9'h1FF, d);
    vec++; if (d !== 32'h1) begin errs++; $display("FAIL busy_ctrl_read: got %h want 00000001", d); end
    wait_words(base + 512, 3000, ok);
    vec++; if (!ok) begin errs++; $display("FAIL poke_timeout: got %0d writes want 512", wr_cnt - base); end
    repeat (30) @(negedge clk);
    vec++; if (wr_cnt != base + 512) begin errs++; $display("FAIL poke_restart: got %0d writes want 512", wr_cnt - base); end
    vec++; if (log_errs(base, 32'h2000) != 0) begin errs++; $display("FAIL poke_sequence: got %0d bad want 0", log_errs(base, 32'h2000)); end
    vec++; if (mem[5] !== 16'h0100) begin errs++; $display("FAIL poke_sram: got %h want 0100", mem[5]); end
    sr(9'h1FE, d);
    vec++; if (d !== 32'h2000) begin errs++; $display("FAIL poke_dest: got %h want 00002000", d); end
    vec++; if (ovl_err != 0) begin errs++; $display("FAIL rden_wren_overlap: got %0d want 0", ovl_err); end
  endtask

  task automatic test_wrap;
    bit ok;
    int base;
    sw(9'h1FE, 32'hFFFFFC00, 1);
    base = wr_cnt;
    sw(9'h1FF, 32'h0, 1);
    wait_words(base + 512, 3000, ok);
    vec++; if (!ok) begin errs++; $display("FAIL wrap_timeout: got %0d writes want 512", wr_cnt - base); end
    vec++;
    if (addr_log[(base + 255) % 4096] !== 32'hFFFFFFFC || addr_log[(base + 256) % 4096] !== 32'h0) begin
      errs++; $display("FAIL wrap_point: got %h,%h want fffffffc,00000000", addr_log[(base + 255) % 4096], addr_log[(base + 256) % 4096]);
    end
    vec++; if (addr_log[(base + 511) % 4096] !== 32'h3FC) begin errs++; $display("FAIL wrap_last: got %h want 000003fc", addr_log[(base + 511) % 4096]); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d;
    bit ok;
    int base, snap;
    base = wr_cnt;
    sw(9'h1FF, 32'h0, 1);
    wait_words(base + 10, 200, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rst_pre_timeout: got %0d writes want 10", wr_cnt - base); end
    while (!master_write) @(posedge clk);
    #2;
    n_rst = 0;
    #1;
    vec++;
    if ({master_write, f_rden, f_wren} !== 3'b000) begin
      errs++; $display("FAIL rst_abort: got mw=%b rden=%b wren=%b want 000", master_write, f_rden, f_wren);
    end
    repeat (2) @(negedge clk);
    n_rst = 1;
    snap = wr_cnt;
    sr(9'h1FF, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL rst_ctrl: got %h want 00000000", d); end
    sr(9'h1FE, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL rst_dest: got %h want 00000000", d); end
    sr(9'd0, d);
    vec++; if (d !== 32'h100) begin errs++; $display("FAIL rst_sram_kept: got %h want 00000100", d); end
    vec++; if (wr_cnt != snap) begin errs++; $display("FAIL rst_idle: got %0d stray writes want 0", wr_cnt - snap); end
    base = wr_cnt;
    sw(9'h1FF, 32'h0, 1);
    wait_words(base + 512, 3000, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rst_run_timeout: got %0d writes want 512", wr_cnt - base); end
    vec++;
    if (addr_log[base % 4096] !== 32'h0 || addr_log[(base + 511) % 4096] !== 32'h7FC) begin
      errs++; $display("FAIL rst_run_addr: got %h..%h want 00000000..000007fc", addr_log[base % 4096], addr_log[(base + 511) % 4096]);
    end
    vec++; if (log_errs(base, 32'h0) != 0) begin errs++; $display("FAIL rst_run_sequence: got %0d bad want 0", log_errs(base, 32'h0)); end
    sr(9'h1FF, d);
    vec++; if (d !== 32'h2) begin errs++; $display("FAIL rst_run_done: got %h want 00000002", d); end
  endtask

  initial begin
    test_reset;
    test_sram_load;
    test_run_basic;
    test_waitrequest;
    test_midrun_pokes;
    test_wrap;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
